rtc_58167_core: RTL

Time-keeping core behind the MM58167 RTC pin wrapper on the Sun-2 board. It holds the BCD calendar counters, RAM latches, interrupt logic and status/command registers. It presents a synchronous register port that the wrapper converts to the chip's D[7:0]/A[4:0]/CS_n/RD_n/WR_n pins. A prescaler divides the system clock to a 1 kHz tick that advances the counters.

---
 rtl/rtc_58167_pkg.sv | 57 +++++
 rtl/rtc_58167_core_counter.sv | 32 +++
 rtl/rtc_58167_core.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rtc_58167_pkg.sv
// Shared constants and helpers for the MM58167-compatible time-keeping core.
package rtc_58167_pkg;

  localparam logic [4:0] ADDR_MSEC   = 5'h00;
  localparam logic [4:0] ADDR_CSEC   = 5'h01;
  localparam logic [4:0] ADDR_SEC    = 5'h02;
  localparam logic [4:0] ADDR_MIN    = 5'h03;
  localparam logic [4:0] ADDR_HOUR   = 5'h04;
  localparam logic [4:0] ADDR_DOW    = 5'h05;
  localparam logic [4:0] ADDR_DOM    = 5'h06;
  localparam logic [4:0] ADDR_MON    = 5'h07;
  localparam logic [4:0] ADDR_ISTAT  = 5'h10;
  localparam logic [4:0] ADDR_ICTRL  = 5'h11;
  localparam logic [4:0] ADDR_CRST   = 5'h12;
  localparam logic [4:0] ADDR_RRST   = 5'h13;
  localparam logic [4:0] ADDR_STATUS = 5'h14;
  localparam logic [4:0] ADDR_GO     = 5'h15;

  localparam int unsigned IRQ_TENTH  = 1;
  localparam int unsigned IRQ_SEC    = 2;
  localparam int unsigned IRQ_MIN    = 3;
  localparam int unsigned IRQ_HOUR   = 4;
  localparam int unsigned IRQ_DAY    = 5;
  localparam int unsigned IRQ_WEEK   = 6;
  localparam int unsigned IRQ_MONTH  = 7;

  typedef struct packed {
    logic [7:0] nxt;
    logic       carry;
  } bcd_step_t;

  // Non-BCD values fall through to binary +1 until they hit the wrap value.
  function automatic bcd_step_t bcd_inc(input logic [7:0] value,
                                        input logic [7:0] max,
                                        input logic [7:0] min);
    bcd_step_t r;
    r.carry = 1'b0;
    if (value == max) begin
      r.nxt   = min;
      r.carry = 1'b1;
    end else if (value[3:0] == 4'h9) begin
      r.nxt = {value[7:4] + 4'h1, 4'h0};
    end else begin
      r.nxt = value + 8'h01;
    end
    return r;
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] month);
    case (month)
      8'h02:                      return 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

endpackage

// File: rtl/rtc_58167_core_counter.sv
// One 8-bit BCD calendar field: load beats clear beats increment.
module rtc_bcd_counter
  import rtc_58167_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       clear,
  input  logic [7:0] min,
  input  logic [7:0] max,
  output logic [7:0] value,
  output logic       carry
);

  bcd_step_t step;

  // A loaded or cleared field did not wrap, so it passes no carry upward.
  always_comb begin
    step  = bcd_inc(value, max, min);
    carry = inc & ~load & ~clear & step.carry;
  end

  always_ff @(posedge clk) begin
    if (reset)      value <= min;
    else if (load)  value <= load_value;
    else if (clear) value <= min;
    else if (inc)   value <= step.nxt;
  end

endmodule

// File: rtl/rtc_58167_core.sv
// MM58167 time-keeping core: prescaler, BCD counter chain, RAM, interrupts.
module rtc_58167_core
  import rtc_58167_pkg::*;
#(
  parameter int unsigned CLK_HZ = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       rd,
  input  logic       wr,
  input  logic [4:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq
);

  localparam int unsigned PRESCALE = CLK_HZ / 1000;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc;
  logic          tick;
  logic          rd_en, wr_en, go;
  logic [7:0]    ld, clr, ld_val, evt, rd_mux;
  logic [7:0]    status, control;
  logic          rollover;
  logic [7:0]    ram [8];

  logic [7:0] msec_val, csec_val, sec_val, mins_val, hour_val, dow_val, dom_val, mon_val;
  logic       msec_carry, csec_carry, sec_carry, mins_carry, hour_carry, dow_carry, dom_carry,
              mon_carry;

  assign rd_en  = cs & rd;
  assign wr_en  = cs & wr;
  assign go     = wr_en && (addr == ADDR_GO);
  assign tick   = (presc == PW'(PRESCALE - 1));
  assign ld_val = (addr == ADDR_MSEC) ? {4'h0, wdata[7:4]} : wdata;

  always_comb begin
    ld  = '0;
    clr = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      ld[i]  = wr_en && (addr == 5'(i));
      clr[i] = (wr_en && (addr == ADDR_CRST) && wdata[i]) || (go && (i < 3));
    end
  end

  rtc_bcd_counter u_msec (.clk(clk), .reset(reset), .inc(tick), .load(ld[0]), .load_value(ld_val),
    .clear(clr[0]), .min(8'h00), .max(8'h09), .value(msec_val), .carry(msec_carry));
  rtc_bcd_counter u_csec (.clk(clk), .reset(reset), .inc(msec_carry), .load(ld[1]),
    .load_value(ld_val), .clear(clr[1]), .min(8'h00), .max(8'h99), .value(csec_val),
    .carry(csec_carry));
  rtc_bcd_counter u_sec (.clk(clk), .reset(reset), .inc(csec_carry), .load(ld[2]),
    .load_value(ld_val), .clear(clr[2]), .min(8'h00), .max(8'h59), .value(sec_val),
    .carry(sec_carry));
  rtc_bcd_counter u_mins (.clk(clk), .reset(reset), .inc(sec_carry), .load(ld[3]),
    .load_value(ld_val), .clear(clr[3]), .min(8'h00), .max(8'h59), .value(mins_val),
    .carry(mins_carry));
  rtc_bcd_counter u_hour (.clk(clk), .reset(reset), .inc(mins_carry), .load(ld[4]),
    .load_value(ld_val), .clear(clr[4]), .min(8'h00), .max(8'h23), .value(hour_val),
    .carry(hour_carry));
  rtc_bcd_counter u_dow (.clk(clk), .reset(reset), .inc(hour_carry), .load(ld[5]),
    .load_value(ld_val), .clear(clr[5]), .min(8'h01), .max(8'h07), .value(dow_val),
    .carry(dow_carry));
  rtc_bcd_counter u_dom (.clk(clk), .reset(reset), .inc(hour_carry), .load(ld[6]),
    .load_value(ld_val), .clear(clr[6]), .min(8'h01), .max(days_in_month(mon_val)),
    .value(dom_val), .carry(dom_carry));
  rtc_bcd_counter u_mon (.clk(clk), .reset(reset), .inc(dom_carry), .load(ld[7]),
    .load_value(ld_val), .clear(clr[7]), .min(8'h01), .max(8'h12), .value(mon_val),
    .carry(mon_carry));

  // Tenths live in the high nibble of csec; they step when hundredths roll 9->0.
  always_comb begin
    evt            = '0;
    evt[IRQ_TENTH] = msec_carry & ~ld[1] & ~clr[1] & (csec_val[3:0] == 4'h9);
    evt[IRQ_SEC]   = csec_carry & ~ld[2] & ~clr[2];
    evt[IRQ_MIN]   = sec_carry & ~ld[3] & ~clr[3];
    evt[IRQ_HOUR]  = mins_carry & ~ld[4] & ~clr[4];
    evt[IRQ_DAY]   = hour_carry & (~(ld[5] | clr[5]) | ~(ld[6] | clr[6]));
    evt[IRQ_WEEK]  = dow_carry;
    evt[IRQ_MONTH] = dom_carry & ~ld[7] & ~clr[7];
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_MSEC:   rd_mux = {msec_val[3:0], 4'h0};
      ADDR_CSEC:   rd_mux = csec_val;
      ADDR_SEC:    rd_mux = sec_val;
      ADDR_MIN:    rd_mux = mins_val;
      ADDR_HOUR:   rd_mux = hour_val;
      ADDR_DOW:    rd_mux = dow_val;
      ADDR_DOM:    rd_mux = dom_val;
      ADDR_MON:    rd_mux = mon_val;
      ADDR_ISTAT:  rd_mux = status;
      ADDR_ICTRL:  rd_mux = control;
      ADDR_STATUS: rd_mux = {7'h00, rollover};
      default:     if (addr[4:3] == 2'b01) rd_mux = ram[addr[2:0]];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc    <= '0;
      rdata    <= '0;
      status   <= '0;
      control  <= '0;
      rollover <= 1'b0;
      irq      <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) ram[i] <= '0;
    end else begin
      presc <= (go || tick) ? '0 : presc + 1'b1;
      irq   <= |(status & control);
      if (rd_en) rdata <= rd_mux;
      // Bits raised in the clearing cycle survive the read-clear.
      status <= ((rd_en && addr == ADDR_ISTAT) ? 8'h00 : status) | evt;
      if (wr_en && addr == ADDR_ICTRL) control <= wdata;
      if (rd_en && addr == ADDR_STATUS) rollover <= 1'b0;
      else if (tick && rd_en && addr[4:3] == 2'b00) rollover <= 1'b1;
      if (wr_en && addr[4:3] == 2'b01) ram[addr[2:0]] <= wdata;
      else if (wr_en && addr == ADDR_RRST)
        for (int unsigned i = 0; i < 8; i++) if (wdata[i]) ram[i] <= '0;
    end
  end

endmodule
